// File: rtl/lz4_match_addr_gen.sv
// LZ4 decoder match address generator: tracks the absolute output byte count and
// turns (offset, length) match commands into overlap-safe copy beats of up to 4 bytes.
module lz4_match_addr_gen #(
  parameter int HIST_AW = 16,
  parameter int LEN_W   = 16
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               lit_valid,
  output logic               lit_ready,
  input  logic [2:0]         lit_bytes,
  input  logic               match_valid,
  output logic               match_ready,
  input  logic [15:0]        match_offset,
  input  logic [LEN_W-1:0]   match_len,
  output logic               cp_valid,
  input  logic               cp_ready,
  output logic [2:0]         cp_bytes,
  output logic [HIST_AW-1:0] cp_rd_addr,
  output logic [HIST_AW-1:0] cp_wr_addr,
  output logic [31:0]        wr_abs_addr,
  output logic               busy,
  output logic               err
);

  typedef enum logic {IDLE, COPY} state_t;

  state_t               state, state_nxt;
  logic [31:0]          wr_cnt;
  logic [HIST_AW-1:0]   rd_ptr;
  logic [LEN_W-1:0]     remain;
  logic [15:0]          off_r;

  logic                 lit_acc, lit_bad;
  logic                 match_acc, match_bad;
  logic                 beat_acc, last_beat;
  logic [2:0]           lim_off, beat_n;
  logic [LEN_W-1:0]     beat_n_ext;

  assign lit_ready   = (state == IDLE);
  assign match_ready = (state == IDLE) & ~lit_valid;
  assign lit_acc     = lit_valid & lit_ready;
  assign lit_bad     = lit_bytes > 3'd4;
  assign match_acc   = match_valid & match_ready;
  // Offset reaching before byte 0 of the stream cannot be resolved.
  assign match_bad   = (match_offset == 16'd0) | ({16'd0, match_offset} > wr_cnt) |
                       (match_len == '0);

  // Beat size never exceeds the match distance, so every read byte is already written.
  assign lim_off     = (off_r < 16'd4) ? off_r[2:0] : 3'd4;
  assign beat_n_ext  = {{(LEN_W-3){1'b0}}, lim_off};
  assign beat_n      = (remain < beat_n_ext) ? remain[2:0] : lim_off;
  assign last_beat   = (remain == {{(LEN_W-3){1'b0}}, beat_n});
  assign beat_acc    = cp_valid & cp_ready;

  assign cp_valid    = (state == COPY);
  assign busy        = cp_valid;
  assign cp_bytes    = cp_valid ? beat_n : 3'd0;
  assign cp_rd_addr  = cp_valid ? rd_ptr : '0;
  assign cp_wr_addr  = cp_valid ? wr_cnt[HIST_AW-1:0] : '0;
  assign wr_abs_addr = wr_cnt;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (match_acc && !match_bad) state_nxt = COPY;
      COPY:    if (beat_acc && last_beat)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_cnt <= '0;
      rd_ptr <= '0;
      remain <= '0;
      off_r  <= '0;
      err    <= 1'b0;
    end else begin
      if (lit_acc) begin
        if (lit_bad) err    <= 1'b1;
        else         wr_cnt <= wr_cnt + 32'(lit_bytes);
      end
      if (match_acc) begin
        if (match_bad) begin
          err <= 1'b1;
        end else begin
          rd_ptr <= HIST_AW'(wr_cnt - {16'd0, match_offset});
          remain <= match_len;
          off_r  <= match_offset;
        end
      end
      if (beat_acc) begin
        rd_ptr <= rd_ptr + HIST_AW'(beat_n);
        wr_cnt <= wr_cnt + 32'(beat_n);
        remain <= remain - beat_n_ext;
      end
    end
  end

endmodule

// File: tb/tb_lz4_match_addr_gen.sv
// Directed bench for lz4_match_addr_gen: table-driven copy sequences on a 16-bit
// history instance plus hand sequences for errors, arbitration, wrap and mid-copy reset.
module tb_lz4_match_addr_gen;

  logic        clk = 1'b0;
  logic        rstN;
  always #5 clk = ~clk;

  // 16-bit history instance
  logic        lit_valid, lit_ready, match_valid, match_ready, cp_valid, cp_ready, busy, err;
  logic [2:0]  lit_bytes, cp_bytes;
  logic [15:0] match_offset, match_len, cp_rd_addr, cp_wr_addr;
  logic [31:0] wr_abs_addr;

  // 4-bit history instance for wrap checks
  logic        lit_valid4, lit_ready4, match_valid4, match_ready4, cp_valid4, cp_ready4, busy4, err4;
  logic [2:0]  lit_bytes4, cp_bytes4;
  logic [15:0] match_offset4, match_len4;
  logic [3:0]  cp_rd_addr4, cp_wr_addr4;
  logic [31:0] wr_abs_addr4;

  lz4_match_addr_gen #(.HIST_AW(16), .LEN_W(16)) dut (
    .clk(clk), .rstN(rstN),
    .lit_valid(lit_valid), .lit_ready(lit_ready), .lit_bytes(lit_bytes),
    .match_valid(match_valid), .match_ready(match_ready),
    .match_offset(match_offset), .match_len(match_len),
    .cp_valid(cp_valid), .cp_ready(cp_ready), .cp_bytes(cp_bytes),
    .cp_rd_addr(cp_rd_addr), .cp_wr_addr(cp_wr_addr),
    .wr_abs_addr(wr_abs_addr), .busy(busy), .err(err)
  );

  lz4_match_addr_gen #(.HIST_AW(4), .LEN_W(16)) dut4 (
    .clk(clk), .rstN(rstN),
    .lit_valid(lit_valid4), .lit_ready(lit_ready4), .lit_bytes(lit_bytes4),
    .match_valid(match_valid4), .match_ready(match_ready4),
    .match_offset(match_offset4), .match_len(match_len4),
    .cp_valid(cp_valid4), .cp_ready(cp_ready4), .cp_bytes(cp_bytes4),
    .cp_rd_addr(cp_rd_addr4), .cp_wr_addr(cp_wr_addr4),
    .wr_abs_addr(wr_abs_addr4), .busy(busy4), .err(err4)
  );

  typedef struct {
    bit          rst;
    bit          lv;
    logic [2:0]  lb;
    bit          mv;
    logic [15:0] off;
    logic [15:0] len;
    bit          rdy;
    bit          cv;
    logic [2:0]  n;
    logic [15:0] rd;
    logic [15:0] wr;
    logic [31:0] abs;
    bit          lr;
    bit          mr;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic add(input bit rst, input bit lv, input logic [2:0] lb, input bit mv,
                     input logic [15:0] off, input logic [15:0] len, input bit rdy,
                     input bit cv, input logic [2:0] n, input logic [15:0] rd,
                     input logic [15:0] wr, input logic [31:0] abs, input bit lr, input bit mr);
    vec_t v;
    v.rst = rst; v.lv = lv; v.lb = lb; v.mv = mv; v.off = off; v.len = len; v.rdy = rdy;
    v.cv = cv; v.n = n; v.rd = rd; v.wr = wr; v.abs = abs; v.lr = lr; v.mr = mr;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    lit_valid = 0; lit_bytes = 0; match_valid = 0; match_offset = 0; match_len = 0; cp_ready = 1;
    lit_valid4 = 0; lit_bytes4 = 0; match_valid4 = 0; match_offset4 = 0; match_len4 = 0;
    cp_ready4 = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
  endtask

  task automatic lit(input logic [2:0] b);
    lit_valid = 1; lit_bytes = b;
    tick();
    lit_valid = 0; lit_bytes = 0;
  endtask

  task automatic lit4(input logic [2:0] b);
    lit_valid4 = 1; lit_bytes4 = b;
    tick();
    lit_valid4 = 0; lit_bytes4 = 0;
  endtask

  initial begin
    //   rst lv lb mv off len rdy | cv n rd wr abs lr mr
    // basic copy: offset 10, len 6
    add(1, 1, 4, 0,  0, 0, 1,  0, 0,  0,  0,  0, 1, 0);
    add(0, 1, 4, 0,  0, 0, 1,  0, 0,  0,  0,  4, 1, 0);
    add(0, 1, 2, 0,  0, 0, 1,  0, 0,  0,  0,  8, 1, 0);
    add(0, 0, 0, 1, 10, 6, 1,  0, 0,  0,  0, 10, 1, 1);
    add(0, 0, 0, 0,  0, 0, 1,  1, 4,  0, 10, 10, 0, 0);
    add(0, 0, 0, 0,  0, 0, 1,  1, 2,  4, 14, 14, 0, 0);
    add(0, 0, 0, 0,  0, 0, 1,  0, 0,  0,  0, 16, 1, 1);
    // overlap: offset 3, len 7
    add(1, 1, 4, 0,  0, 0, 1,  0, 0,  0,  0,  0, 1, 0);
    add(0, 1, 4, 0,  0, 0, 1,  0, 0,  0,  0,  4, 1, 0);
    add(0, 0, 0, 1,  3, 7, 1,  0, 0,  0,  0,  8, 1, 1);
    add(0, 0, 0, 0,  0, 0, 1,  1, 3,  5,  8,  8, 0, 0);
    add(0, 0, 0, 0,  0, 0, 1,  1, 3,  8, 11, 11, 0, 0);
    add(0, 0, 0, 0,  0, 0, 1,  1, 1, 11, 14, 14, 0, 0);
    add(0, 0, 0, 0,  0, 0, 1,  0, 0,  0,  0, 15, 1, 1);
    // RLE: offset 1, len 5, with a 3-cycle stall
    add(1, 1, 3, 0,  0, 0, 1,  0, 0,  0,  0,  0, 1, 0);
    add(0, 0, 0, 1,  1, 5, 1,  0, 0,  0,  0,  3, 1, 1);
    add(0, 0, 0, 0,  0, 0, 1,  1, 1,  2,  3,  3, 0, 0);
    add(0, 0, 0, 0,  0, 0, 1,  1, 1,  3,  4,  4, 0, 0);
    add(0, 0, 0, 0,  0, 0, 0,  1, 1,  4,  5,  5, 0, 0);
    add(0, 0, 0, 0,  0, 0, 0,  1, 1,  4,  5,  5, 0, 0);
    add(0, 0, 0, 0,  0, 0, 0,  1, 1,  4,  5,  5, 0, 0);
    add(0, 0, 0, 0,  0, 0, 1,  1, 1,  4,  5,  5, 0, 0);
    add(0, 0, 0, 0,  0, 0, 1,  1, 1,  5,  6,  6, 0, 0);
    add(0, 0, 0, 0,  0, 0, 1,  1, 1,  6,  7,  7, 0, 0);
    add(0, 0, 0, 0,  0, 0, 1,  0, 0,  0,  0,  8, 1, 1);

    idle_inputs();
    rstN = 1'b0;
    #2;
    chk("reset wr_abs_addr", wr_abs_addr, 0);
    chk("reset cp_valid", cp_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset err", err, 0);
    chk("reset lit_ready", lit_ready, 1);
    chk("reset match_ready", match_ready, 1);
    chk("reset cp_bytes", cp_bytes, 0);
    tick();
    rstN = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      lit_valid = tbl[i].lv; lit_bytes = tbl[i].lb;
      match_valid = tbl[i].mv; match_offset = tbl[i].off; match_len = tbl[i].len;
      cp_ready = tbl[i].rdy;
      #1;
      chk($sformatf("row%0d cp_valid", i), cp_valid, tbl[i].cv);
      chk($sformatf("row%0d busy", i), busy, tbl[i].cv);
      chk($sformatf("row%0d cp_bytes", i), cp_bytes, tbl[i].n);
      chk($sformatf("row%0d cp_rd_addr", i), cp_rd_addr, tbl[i].rd);
      chk($sformatf("row%0d cp_wr_addr", i), cp_wr_addr, tbl[i].wr);
      chk($sformatf("row%0d wr_abs_addr", i), wr_abs_addr, tbl[i].abs);
      chk($sformatf("row%0d lit_ready", i), lit_ready, tbl[i].lr);
      chk($sformatf("row%0d match_ready", i), match_ready, tbl[i].mr);
      chk($sformatf("row%0d err", i), err, 0);
      tick();
    end

    // zero offset
    do_reset();
    lit(4); lit(4); lit(2);
    match_valid = 1; match_offset = 0; match_len = 3;
    tick();
    match_valid = 0;
    chk("off0 err", err, 1);
    chk("off0 cp_valid", cp_valid, 0);
    chk("off0 lit_ready", lit_ready, 1);
    tick();
    chk("off0 no beat", cp_valid, 0);
    chk("off0 wr_abs_addr", wr_abs_addr, 10);

    // offset beyond stream start
    do_reset();
    chk("err cleared by reset", err, 0);
    lit(4); lit(4); lit(2);
    match_valid = 1; match_offset = 20; match_len = 2;
    tick();
    match_valid = 0;
    chk("off20 err", err, 1);
    chk("off20 cp_valid", cp_valid, 0);
    tick();
    chk("off20 no beat", cp_valid, 0);
    // offset == wr_cnt is legal and err keeps running
    match_valid = 1; match_offset = 10; match_len = 1;
    tick();
    match_valid = 0;
    chk("off=wr cp_valid", cp_valid, 1);
    chk("off=wr cp_rd_addr", cp_rd_addr, 0);
    chk("off=wr cp_bytes", cp_bytes, 1);
    tick();
    chk("off=wr wr_abs_addr", wr_abs_addr, 11);
    chk("err sticky", err, 1);

    // illegal literal count
    do_reset();
    lit(3);
    lit(5);
    chk("lit5 err", err, 1);
    chk("lit5 wr_abs_addr", wr_abs_addr, 3);

    // zero length
    do_reset();
    lit(4);
    match_valid = 1; match_offset = 2; match_len = 0;
    tick();
    match_valid = 0;
    chk("len0 err", err, 1);
    chk("len0 cp_valid", cp_valid, 0);

    // literal wins over a simultaneous match
    do_reset();
    lit_valid = 1; lit_bytes = 2; match_valid = 1; match_offset = 1; match_len = 1;
    #1;
    chk("arb match_ready low", match_ready, 0);
    chk("arb lit_ready", lit_ready, 1);
    tick();
    lit_valid = 0; lit_bytes = 0;
    #1;
    chk("arb lit taken", wr_abs_addr, 2);
    chk("arb match_ready high", match_ready, 1);
    chk("arb no beat yet", cp_valid, 0);
    tick();
    match_valid = 0;
    chk("arb beat valid", cp_valid, 1);
    chk("arb beat rd", cp_rd_addr, 1);
    chk("arb beat wr", cp_wr_addr, 2);
    tick();
    chk("arb done wr_abs_addr", wr_abs_addr, 3);
    chk("arb err", err, 0);

    // 4-bit history wrap, then reset mid-copy
    do_reset();
    lit4(4); lit4(4); lit4(4); lit4(2);
    chk("wrap wr_abs_addr", wr_abs_addr4, 14);
    match_valid4 = 1; match_offset4 = 2; match_len4 = 4;
    tick();
    match_valid4 = 0;
    chk("wrap b1 cp_valid", cp_valid4, 1);
    chk("wrap b1 rd", cp_rd_addr4, 12);
    chk("wrap b1 wr", cp_wr_addr4, 14);
    chk("wrap b1 n", cp_bytes4, 2);
    tick();
    chk("wrap b2 cp_valid", cp_valid4, 1);
    chk("wrap b2 rd", cp_rd_addr4, 14);
    chk("wrap b2 wr", cp_wr_addr4, 0);
    chk("wrap b2 n", cp_bytes4, 2);
    chk("wrap b2 wr_abs_addr", wr_abs_addr4, 16);
    rstN = 1'b0;
    #1;
    chk("midreset cp_valid", cp_valid4, 0);
    chk("midreset busy", busy4, 0);
    chk("midreset wr_abs_addr", wr_abs_addr4, 0);
    chk("midreset lit_ready", lit_ready4, 1);
    tick();
    rstN = 1'b1;
    tick();
    chk("after reset idle", cp_valid4, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
